// File: rtl/universal_counter_scheduler_pkg.sv
// Shared types for the universal counter scheduler: FSM states, completion causes
// and the default counter width.
package universal_counter_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } ucs_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ABORT    = 2'd1,
    ERR_MISMATCH = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } ucs_cause_e;

  function automatic logic cause_is_error(ucs_cause_e c);
    return (c != ERR_NONE);
  endfunction

endpackage

// File: rtl/universal_counter_scheduler_if.sv
// Bundle between the scheduler, its requesters and the shared four_universal_counter.
// master = requester/counter side, slave = scheduler.
interface universal_counter_scheduler_if
  import universal_counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 20
);
  localparam int TW = $clog2(TIMEOUT + 1);

  // req is a level held by a requester; grant is the registered one-hot owner,
  // held from LOAD through DONE; done is a one-cycle pulse to the owner, and
  // err/ticks are valid with it and held until the next job enters LOAD.
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] start;
  logic                  abort;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  err;
  logic [TW-1:0]         ticks;
  logic                  busy;

  logic [WIDTH-1:0]      ctr_din;
  logic                  ctr_load;
  logic                  ctr_count;
  logic [WIDTH-1:0]      ctr_acount;
  logic                  ctr_cout;

  ucs_state_e            dbg_state;
  ucs_cause_e            dbg_cause;

  modport master (
    output req, start, abort, ctr_acount, ctr_cout,
    input  grant, done, err, ticks, busy, ctr_din, ctr_load, ctr_count,
    input  dbg_state, dbg_cause
  );

  modport slave (
    input  req, start, abort, ctr_acount, ctr_cout,
    output grant, done, err, ticks, busy, ctr_din, ctr_load, ctr_count,
    output dbg_state, dbg_cause
  );

endinterface

// File: rtl/universal_counter_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request searching upward from
// i_ptr+1 with wrap-around, returned as one-hot and as an index.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  logic [PW-1:0] w_cand;

  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int off = 1; off <= NREQ; off++) begin
      w_cand = PW'((int'(i_ptr) + off) % NREQ);
      if (!o_any && i_req[w_cand]) begin
        o_any         = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/universal_counter_scheduler.sv
// Shares one four_universal_counter among NREQ requesters: round-robin pick,
// load start value, count to all-ones, report elapsed count cycles and errors.
module universal_counter_scheduler
  import universal_counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 20
) (
  input logic                          clk,
  input logic                          reset,
  universal_counter_scheduler_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  ucs_state_e       r_state;
  ucs_cause_e       r_cause;
  logic [NREQ-1:0]  r_grant;
  logic [NREQ-1:0]  r_done;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_owner;
  logic             r_err;
  logic [TW-1:0]    r_ticks;
  logic [TW-1:0]    r_cnt;
  logic [TW-1:0]    r_timer;
  logic [WIDTH-1:0] r_din;

  logic [NREQ-1:0]  w_win;
  logic [PW-1:0]    w_win_idx;
  logic             w_any;
  logic [WIDTH-1:0] w_win_start;
  logic             w_in_count;
  logic             w_mismatch;
  logic             w_count;
  logic             w_timeout;
  logic             w_finish;
  ucs_cause_e       w_cause;
  logic [TW-1:0]    w_ticks_next;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_gnt (w_win),
    .o_idx (w_win_idx),
    .o_any (w_any)
  );

  assign w_win_start = bus.start[int'(w_win_idx)*WIDTH +: WIDTH];

  // The first COUNT cycle verifies the load landed; no count is issued if it did not.
  assign w_in_count   = (r_state == ST_COUNT);
  assign w_mismatch   = w_in_count && (r_timer == '0) && (bus.ctr_acount != r_din);
  assign w_count      = w_in_count && !bus.ctr_cout && !bus.abort && !w_mismatch;
  assign w_timeout    = (r_timer == TIMER_LAST);
  assign w_ticks_next = r_cnt + TW'(w_count);

  always_comb begin
    w_cause  = ERR_NONE;
    w_finish = 1'b0;
    if (bus.abort) begin
      w_cause  = ERR_ABORT;
      w_finish = 1'b1;
    end else if (w_mismatch) begin
      w_cause  = ERR_MISMATCH;
      w_finish = 1'b1;
    end else if (bus.ctr_cout) begin
      w_cause  = ERR_NONE;
      w_finish = 1'b1;
    end else if (w_timeout) begin
      w_cause  = ERR_TIMEOUT;
      w_finish = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cause <= ERR_NONE;
      r_grant <= '0;
      r_done  <= '0;
      r_ptr   <= PW'(NREQ - 1);
      r_owner <= '0;
      r_err   <= 1'b0;
      r_ticks <= '0;
      r_cnt   <= '0;
      r_timer <= '0;
      r_din   <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_win;
            r_owner <= w_win_idx;
            r_din   <= w_win_start;
            r_err   <= 1'b0;
            r_ticks <= '0;
            r_cause <= ERR_NONE;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_cnt   <= '0;
          r_timer <= '0;
          if (bus.abort) begin
            r_done  <= r_grant;
            r_err   <= 1'b1;
            r_cause <= ERR_ABORT;
            r_ticks <= '0;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          r_cnt   <= w_ticks_next;
          r_timer <= r_timer + TW'(1);
          if (w_finish) begin
            r_done  <= r_grant;
            r_err   <= cause_is_error(w_cause);
            r_cause <= w_cause;
            r_ticks <= w_ticks_next;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_grant <= '0;
          r_ptr   <= r_owner;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant     = r_grant;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.ticks     = r_ticks;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.ctr_din   = r_din;
  assign bus.ctr_load  = (r_state == ST_LOAD);
  assign bus.ctr_count = w_count;
  assign bus.dbg_state = r_state;
  assign bus.dbg_cause = r_cause;

  a_load_count_excl: assert property (@(posedge clk) disable iff (reset)
    !(bus.ctr_load && bus.ctr_count));
  a_grant_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(r_grant));
  a_done_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(r_done));

endmodule

// File: tb/tb_universal_counter_scheduler.sv
// Directed bench for universal_counter_scheduler driving a behavioural
// four_universal_counter; expected values are hand-computed from start values.
module tb_universal_counter_scheduler;
  import universal_counter_pkg::*;

  localparam int WIDTH   = 4;
  localparam int NREQ    = 2;
  localparam int TIMEOUT = 20;
  localparam int TW      = $clog2(TIMEOUT + 1);
  localparam int LIMIT   = 60;

  logic             clk;
  logic             reset;
  logic             tie_cout_low;
  logic             corrupt_load;
  logic [WIDTH-1:0] ctr_val = '0;
  int               n_checks = 0;
  int               n_pass = 0;
  logic [TW-1:0]    exp_q[$];

  universal_counter_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) bus ();

  universal_counter_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Counter model: not cleared by the scheduler reset.
  always @(posedge clk) begin
    if (bus.ctr_load) ctr_val <= corrupt_load ? (bus.ctr_din ^ 4'd1) : bus.ctr_din;
    else if (bus.ctr_count) ctr_val <= ctr_val + 4'd1;
  end
  assign bus.ctr_acount = ctr_val;
  assign bus.ctr_cout   = (ctr_val == 4'hF) && !tie_cout_low;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset        = 1'b1;
    bus.req      = '0;
    bus.start    = '0;
    bus.abort    = 1'b0;
    tie_cout_low = 1'b0;
    corrupt_load = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_grant(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.grant == '0 && cyc < LIMIT);
    if (bus.grant == '0) begin
      n_checks++;
      $display("FAIL wait_grant: no grant after %0d cycles, required within %0d", cyc, LIMIT);
    end
  endtask

  task automatic wait_done(output int cyc, output int cnt);
    cyc = 0;
    cnt = 0;
    while (cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (bus.done != '0) break;
      if (bus.ctr_count) cnt++;
    end
    if (bus.done == '0) begin
      n_checks++;
      $display("FAIL wait_done: no done after %0d cycles, required within %0d", cyc, LIMIT);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset        = 1'b1;
    bus.req      = '0;
    bus.start    = '0;
    bus.abort    = 1'b0;
    tie_cout_low = 1'b0;
    corrupt_load = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.grant, bus.done, bus.err, bus.ticks, bus.busy, bus.ctr_load, bus.ctr_count, bus.ctr_din} !== '0)
      $display("FAIL reset_outputs: got grant=%b done=%b err=%b ticks=%0d busy=%b load=%b count=%b din=%0d required all 0",
               bus.grant, bus.done, bus.err, bus.ticks, bus.busy, bus.ctr_load, bus.ctr_count, bus.ctr_din);
    else n_pass++;
    n_checks++;
    if (bus.dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d required %0d", bus.dbg_state, ST_IDLE);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL idle_abort_ignored: got busy=%b required 0", bus.busy);
    else n_pass++;
  endtask

  task automatic test_single_job();
    int cyc, cnt;
    bus.start = {4'd0, 4'd2};
    bus.req   = 2'b01;
    wait_grant(cyc);
    n_checks++;
    if (bus.grant !== 2'b01) $display("FAIL single_grant: got %b required 01", bus.grant);
    else n_pass++;
    n_checks++;
    if ({bus.ctr_load, bus.ctr_count, bus.ctr_din} !== {2'b10, 4'd2})
      $display("FAIL single_load: got load=%b count=%b din=%0d required load=1 count=0 din=2",
               bus.ctr_load, bus.ctr_count, bus.ctr_din);
    else n_pass++;
    bus.req = 2'b00;
    wait_done(cyc, cnt);
    n_checks++;
    if (cyc !== 15) $display("FAIL single_latency: got %0d cycles LOAD->done required 15", cyc);
    else n_pass++;
    n_checks++;
    if (cnt !== 13) $display("FAIL single_count_cycles: got %0d required 13", cnt);
    else n_pass++;
    n_checks++;
    if ({bus.done, bus.err, bus.ticks} !== {2'b01, 1'b0, 5'd13})
      $display("FAIL single_done: got done=%b err=%b ticks=%0d required done=01 err=0 ticks=13",
               bus.done, bus.err, bus.ticks);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({bus.done, bus.grant, bus.busy, bus.ticks} !== {2'b00, 2'b00, 1'b0, 5'd13})
      $display("FAIL single_after: got done=%b grant=%b busy=%b ticks=%0d required 00 00 0 13",
               bus.done, bus.grant, bus.busy, bus.ticks);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int cyc, cnt;
    logic [NREQ-1:0] g_exp[3];
    logic [TW-1:0] t_exp;
    g_exp = '{2'b01, 2'b10, 2'b01};
    do_reset();
    exp_q.push_back(5'd3);
    exp_q.push_back(5'd5);
    exp_q.push_back(5'd3);
    bus.start = {4'd10, 4'd12};
    bus.req   = 2'b11;
    for (int j = 0; j < 3; j++) begin
      wait_grant(cyc);
      if (j > 0) begin
        n_checks++;
        if (cyc !== 2) $display("FAIL rr_gap_%0d: got %0d cycles done->LOAD required 2", j, cyc);
        else n_pass++;
      end
      n_checks++;
      if (bus.grant !== g_exp[j]) $display("FAIL rr_grant_%0d: got %b required %b", j, bus.grant, g_exp[j]);
      else n_pass++;
      wait_done(cyc, cnt);
      if (j == 2) bus.req = 2'b00;
      t_exp = exp_q.pop_front();
      n_checks++;
      if ({bus.done, bus.err, bus.ticks} !== {g_exp[j], 1'b0, t_exp})
        $display("FAIL rr_done_%0d: got done=%b err=%b ticks=%0d required done=%b err=0 ticks=%0d",
                 j, bus.done, bus.err, bus.ticks, g_exp[j], t_exp);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_all_ones();
    int cyc, cnt;
    bus.start = {4'd0, 4'd15};
    bus.req   = 2'b01;
    wait_grant(cyc);
    bus.req = 2'b00;
    wait_done(cyc, cnt);
    n_checks++;
    if ({cyc[3:0], cnt[3:0]} !== {4'd2, 4'd0})
      $display("FAIL allones_timing: got %0d cycles %0d counts required 2 cycles 0 counts", cyc, cnt);
    else n_pass++;
    n_checks++;
    if ({bus.done, bus.err, bus.ticks} !== {2'b01, 1'b0, 5'd0})
      $display("FAIL allones_done: got done=%b err=%b ticks=%0d required 01 0 0", bus.done, bus.err, bus.ticks);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int cyc;
    bus.start = {4'd0, 4'd3};
    bus.req   = 2'b01;
    wait_grant(cyc);
    bus.req = 2'b00;
    repeat (4) @(negedge clk);
    bus.abort = 1'b1;
    #1;
    n_checks++;
    if ({bus.dbg_state, bus.ctr_count} !== {ST_COUNT, 1'b0})
      $display("FAIL abort_count_low: got state=%0d count=%b required state=2 count=0", bus.dbg_state, bus.ctr_count);
    else n_pass++;
    @(negedge clk);
    bus.abort = 1'b0;
    n_checks++;
    if ({bus.done, bus.err, bus.ticks, bus.dbg_cause} !== {2'b01, 1'b1, 5'd3, ERR_ABORT})
      $display("FAIL abort_done: got done=%b err=%b ticks=%0d cause=%0d required 01 1 3 %0d",
               bus.done, bus.err, bus.ticks, bus.dbg_cause, ERR_ABORT);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int cyc, cnt;
    tie_cout_low = 1'b1;
    bus.start = {4'd0, 4'd0};
    bus.req   = 2'b01;
    wait_grant(cyc);
    bus.req = 2'b00;
    wait_done(cyc, cnt);
    n_checks++;
    if (cyc !== 21 || cnt !== 20)
      $display("FAIL timeout_timing: got %0d cycles %0d counts required 21 cycles 20 counts", cyc, cnt);
    else n_pass++;
    n_checks++;
    if ({bus.done, bus.err, bus.ticks, bus.dbg_cause} !== {2'b01, 1'b1, 5'd20, ERR_TIMEOUT})
      $display("FAIL timeout_done: got done=%b err=%b ticks=%0d cause=%0d required 01 1 20 %0d",
               bus.done, bus.err, bus.ticks, bus.dbg_cause, ERR_TIMEOUT);
    else n_pass++;
    tie_cout_low = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_mismatch();
    int cyc, cnt;
    corrupt_load = 1'b1;
    bus.start = {4'd0, 4'd5};
    bus.req   = 2'b01;
    wait_grant(cyc);
    bus.req = 2'b00;
    wait_done(cyc, cnt);
    corrupt_load = 1'b0;
    n_checks++;
    if (cyc !== 2 || cnt !== 0)
      $display("FAIL mismatch_timing: got %0d cycles %0d counts required 2 cycles 0 counts", cyc, cnt);
    else n_pass++;
    n_checks++;
    if ({bus.done, bus.err, bus.ticks, bus.dbg_cause} !== {2'b01, 1'b1, 5'd0, ERR_MISMATCH})
      $display("FAIL mismatch_done: got done=%b err=%b ticks=%0d cause=%0d required 01 1 0 %0d",
               bus.done, bus.err, bus.ticks, bus.dbg_cause, ERR_MISMATCH);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_job();
    int cyc, cnt;
    bus.start = {4'd0, 4'd0};
    bus.req   = 2'b01;
    wait_grant(cyc);
    bus.req = 2'b00;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.ctr_count !== 1'b1) $display("FAIL midjob_counting: got count=%b required 1", bus.ctr_count);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.grant, bus.ctr_count, bus.ctr_load, bus.busy, bus.done} !== '0)
      $display("FAIL midjob_reset: got grant=%b count=%b load=%b busy=%b done=%b required all 0",
               bus.grant, bus.ctr_count, bus.ctr_load, bus.busy, bus.done);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    bus.start = {4'd13, 4'd14};
    bus.req   = 2'b11;
    wait_grant(cyc);
    n_checks++;
    if ({bus.grant, bus.ctr_din} !== {2'b01, 4'd14})
      $display("FAIL post_reset_grant: got grant=%b din=%0d required grant=01 din=14", bus.grant, bus.ctr_din);
    else n_pass++;
    bus.req = 2'b00;
    wait_done(cyc, cnt);
    n_checks++;
    if ({bus.done, bus.err, bus.ticks} !== {2'b01, 1'b0, 5'd1})
      $display("FAIL post_reset_done: got done=%b err=%b ticks=%0d required 01 0 1", bus.done, bus.err, bus.ticks);
    else n_pass++;
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_job();
    test_back_to_back();
    test_all_ones();
    test_abort();
    test_timeout();
    test_load_mismatch();
    test_reset_mid_job();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
